jtag_port_sequencer: RTL

Owns the JTAG mux select and the internal TCK clock-enable, and sequences every change of JTAG port ownership between the three sources: the internal controller (`JTAG_INT), external pass-through (`JTAG_EXT) and test mode (`JTAG_TEST).
- Before switching: drains the internal JTAG controller and gates TCK.
- After switching: lets the pins settle and optionally drives a TAP reset on entry to `JTAG_INT.
- Sits between the SPI controller (which issues requests) and the JTAG mux / BUFGCE enable.

---
 rtl/jtag_port_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/jtag_port_sequencer.sv
// Sequences JTAG port ownership changes (internal / external / test) with drain, TCK gating, settle and optional TAP reset.
// Optional feature: define JTAG_EXT_QUIET_EN to require external TCK quiet time before leaving the external source.
`ifndef JTAG_INT
`define JTAG_INT 2'b00
`endif
`ifndef JTAG_EXT
`define JTAG_EXT 2'b01
`endif
`ifndef JTAG_TEST
`define JTAG_TEST 2'b10
`endif

module jtag_port_sequencer #(
  parameter int GUARD_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int TAPRST_CLOCKS = 5,
  parameter int DRAIN_TIMEOUT = 1023,
  parameter int QUIET_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  input  logic       req_tap_reset,
  output logic       req_ready,
  input  logic       ctrl_idle,
  input  logic       ctrl_ce,
  input  logic       ext_tck,
  output logic       jtag_ce,
  output logic [1:0] jtag_sel,
  output logic       tap_override,
  output logic       tap_tms,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  // Handshake: a request is taken on any clk edge where req_valid && req_ready.
  // req_ready is high only in IDLE; the requester holds req_valid until accepted.

  localparam int MAX_GS  = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_TD  = (TAPRST_CLOCKS > DRAIN_TIMEOUT) ? TAPRST_CLOCKS : DRAIN_TIMEOUT;
  localparam int MAX_GSTD = (MAX_GS > MAX_TD) ? MAX_GS : MAX_TD;
  localparam int MAX_P   = (MAX_GSTD > QUIET_CYCLES) ? MAX_GSTD : QUIET_CYCLES;
  localparam int CW      = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] GUARD_LAST  = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TAPRST_LAST = CW'(TAPRST_CLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_GATE    = 3'd2,
    S_SWITCH  = 3'd3,
    S_SETTLE  = 3'd4,
    S_TAPRST  = 3'd5,
    S_TAPIDLE = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [1:0]    tgt_sel;
  logic          tgt_rst;
  logic          err_nx;
  logic          ce_force0;
  logic          ce_force1;
  logic          quiet_ok;
  logic          sel_legal;
  logic          req_eff_rst;
  logic          counting;

  assign sel_legal   = (req_sel == `JTAG_INT) || (req_sel == `JTAG_EXT) || (req_sel == `JTAG_TEST);
  assign req_eff_rst = req_tap_reset && (req_sel == `JTAG_INT);
  assign dbg_state   = state;

  // Outside the forced windows the internal controller owns TCK, but only while it owns the port.
  assign jtag_ce = ce_force1 || (!ce_force0 && ctrl_ce && (jtag_sel == `JTAG_INT));

`ifdef JTAG_EXT_QUIET_EN
  logic [1:0]    ext_sync;
  logic          ext_prev;
  logic          ext_edge;
  logic [CW-1:0] quiet_cnt;

  assign ext_edge = ext_sync[1] ^ ext_prev;

  // Quiet count restarts on every synchronised edge and on each DRAIN entry; saturates at the target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_sync  <= 2'b00;
      ext_prev  <= 1'b0;
      quiet_cnt <= '0;
    end else begin
      ext_sync <= {ext_sync[0], ext_tck};
      ext_prev <= ext_sync[1];
      if (state != S_DRAIN || ext_edge) begin
        quiet_cnt <= '0;
      end else if (quiet_cnt != CW'(QUIET_CYCLES)) begin
        quiet_cnt <= quiet_cnt + 1'b1;
      end
    end
  end

  assign quiet_ok = (jtag_sel != `JTAG_EXT) || (quiet_cnt == CW'(QUIET_CYCLES));
`else
  logic unused_ext_tck;
  assign unused_ext_tck = ext_tck;
  assign quiet_ok       = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!sel_legal) begin
            err_nx = 1'b1;
          end else if (req_sel == jtag_sel && !req_eff_rst) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (ctrl_idle && quiet_ok) begin
          state_nx = S_GATE;
        end else if (cnt == DRAIN_LAST) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end
      end
      S_GATE:    if (cnt == GUARD_LAST) state_nx = S_SWITCH;
      S_SWITCH:  state_nx = S_SETTLE;
      S_SETTLE:  if (cnt == SETTLE_LAST) state_nx = tgt_rst ? S_TAPRST : S_DONE;
      S_TAPRST:  if (cnt == TAPRST_LAST) state_nx = S_TAPIDLE;
      S_TAPIDLE: state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  assign counting = (state == S_DRAIN) || (state == S_GATE) ||
                    (state == S_SETTLE) || (state == S_TAPRST);

  // Counters reload on every state entry, so each hold starts from zero.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state) begin
      cnt_nx = '0;
    end else if (counting) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tgt_sel      <= `JTAG_EXT;
      tgt_rst      <= 1'b0;
      jtag_sel     <= `JTAG_EXT;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      tap_override <= 1'b0;
      tap_tms      <= 1'b0;
      ce_force0    <= 1'b0;
      ce_force1    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && req_valid) begin
        tgt_sel <= req_sel;
        tgt_rst <= req_eff_rst;
      end
      if (state == S_SWITCH) begin
        jtag_sel <= tgt_sel;
      end
      req_ready    <= (state_nx == S_IDLE);
      busy         <= (state_nx != S_IDLE);
      done         <= (state_nx == S_DONE);
      err          <= err_nx;
      tap_override <= (state_nx == S_TAPRST) || (state_nx == S_TAPIDLE);
      tap_tms      <= (state_nx == S_TAPRST);
      ce_force0    <= (state_nx == S_GATE) || (state_nx == S_SWITCH) || (state_nx == S_SETTLE);
      ce_force1    <= (state_nx == S_TAPRST) || (state_nx == S_TAPIDLE);
    end
  end

endmodule
